// File: rtl/des_pkg.sv
// Shared types for the DES job dispatcher: block/key widths, job record, FSM states.
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_KEY_W   = 64;

    // One queued job; bit 0 of each field is the MSB (DES numbering).
    typedef struct packed {
        logic [0:DES_BLOCK_W-1] plaintext;
        logic [0:DES_KEY_W-1]   key;
    } des_job_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } disp_state_t;

endpackage

// File: rtl/des_job_fifo.sv
// Register FIFO of DES jobs. Full/empty come from the occupancy count so the
// pointers can wrap naturally at DEPTH (a power of two).
module des_job_fifo
    import des_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  des_job_t         push_data,
    input  logic             pop,
    output des_job_t         head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    des_job_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may complete together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/des_job_dispatcher.sv
// Issue stage in front of the DES engine: queues jobs and hands them out one at
// a time as a registered single-cycle start strobe with plaintext and key.
//
// state     | meaning
// IDLE      | no job in flight; issue when a job is queued and the engine is idle
// ISSUE     | start strobe and job data are on the outputs this cycle
// WAIT_ACK  | waiting for the engine to raise active
// WAIT_DONE | engine is working; waiting for active to fall
module des_job_dispatcher
    import des_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   job_valid_din,
    output logic                   job_ready_dout,
    input  logic [0:DES_BLOCK_W-1] plaintext_din,
    input  logic [0:DES_KEY_W-1]   key_din,
    input  logic                   active_des_engine_din,
    output logic                   start_strobe_dout,
    output logic [0:DES_BLOCK_W-1] plaintext_dout,
    output logic [0:DES_KEY_W-1]   key_dout,
    output logic [CNT_W-1:0]       pending_count_dout
);

    disp_state_t            state_q;
    disp_state_t            state_d;
    des_job_t               head;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   strobe_d;
    logic [0:DES_BLOCK_W-1] plaintext_d;
    logic [0:DES_KEY_W-1]   key_d;

    // No pass-through: a full FIFO refuses a push even when popping.
    assign job_ready_dout = !full;

    des_job_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (job_valid_din),
        .push_data ({plaintext_din, key_din}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (pending_count_dout)
    );

    // Next state, FIFO pop and next output register values.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        strobe_d    = 1'b0;
        plaintext_d = '0;
        key_d       = '0;
        case (state_q)
            IDLE: begin
                if (!empty && !active_des_engine_din) begin
                    state_d     = ISSUE;
                    pop         = 1'b1;
                    strobe_d    = 1'b1;
                    plaintext_d = head.plaintext;
                    key_d       = head.key;
                end
            end
            ISSUE:     state_d = WAIT_ACK;
            WAIT_ACK:  if (active_des_engine_din)  state_d = WAIT_DONE;
            WAIT_DONE: if (!active_des_engine_din) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered engine outputs; data is zero whenever the strobe is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_strobe_dout <= 1'b0;
            plaintext_dout    <= '0;
            key_dout          <= '0;
        end else begin
            start_strobe_dout <= strobe_d;
            plaintext_dout    <= plaintext_d;
            key_dout          <= key_d;
        end
    end

endmodule

// File: tb/tb_des_job_dispatcher.sv
// Self-checking bench for des_job_dispatcher: queue-based reference model,
// per-cycle compare, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_des_job_dispatcher;
    import des_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             job_valid_din;
    logic             job_ready_dout;
    logic [0:63]      plaintext_din;
    logic [0:63]      key_din;
    logic             active_des_engine_din;
    logic             start_strobe_dout;
    logic [0:63]      plaintext_dout;
    logic [0:63]      key_dout;
    logic [CNT_W-1:0] pending_count_dout;

    always #5 clk = ~clk;

    des_job_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .job_valid_din         (job_valid_din),
        .job_ready_dout        (job_ready_dout),
        .plaintext_din         (plaintext_din),
        .key_din               (key_din),
        .active_des_engine_din (active_des_engine_din),
        .start_strobe_dout     (start_strobe_dout),
        .plaintext_dout        (plaintext_dout),
        .key_dout              (key_dout),
        .pending_count_dout    (pending_count_dout)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Reference model: a job queue plus an "in flight" token that is freed once
    // the engine has been seen active (after the issue cycle) and then idle.
    des_job_t    mq[$];
    bit          m_busy = 0;
    bit          m_ack  = 0;
    int          m_age  = 0;
    bit          e_strobe = 0;
    logic [0:63] e_pt = '0;
    logic [0:63] e_key = '0;
    bit          started = 0;
    bit          m_push;
    bit          m_done;

    always @(posedge clk) begin
        started = 1;
        if (!reset_n) begin
            mq.delete();
            m_busy = 0; m_ack = 0; m_age = 0;
            e_strobe = 0; e_pt = '0; e_key = '0;
        end else begin
            m_push   = job_valid_din && (mq.size() < DEPTH);
            m_done   = 0;
            e_strobe = 0; e_pt = '0; e_key = '0;
            if (m_busy) begin
                if (m_ack && !active_des_engine_din) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    if (m_age >= 1 && active_des_engine_din) m_ack = 1;
                    m_age++;
                end
            end
            if (!m_busy && !m_done && mq.size() > 0 && !active_des_engine_din) begin
                e_strobe = 1;
                e_pt     = mq[0].plaintext;
                e_key    = mq[0].key;
                void'(mq.pop_front());
                m_busy = 1; m_ack = 0; m_age = 0;
            end
            if (m_push) mq.push_back(des_job_t'({plaintext_din, key_din}));
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("ready",  128'(job_ready_dout),     128'(mq.size() < DEPTH));
            chk("count",  128'(pending_count_dout), 128'(mq.size()));
            chk("strobe", 128'(start_strobe_dout),  128'(e_strobe));
            chk("pt",     128'(plaintext_dout),     128'(e_pt));
            chk("key",    128'(key_dout),           128'(e_key));
        end
    end

    // Strobe log for order checks.
    int          strobe_cnt = 0;
    logic [0:63] seen_pt[$];
    always @(negedge clk) begin
        if (start_strobe_dout) begin
            strobe_cnt++;
            seen_pt.push_back(plaintext_dout);
        end
    end

    // Engine model: raises active cfg_dly cycles after seeing the strobe and
    // holds it cfg_hold cycles; 'foreign' models another master owning it.
    bit foreign  = 0;
    bit rand_eng = 0;
    bit eng_act  = 0;
    bit eng_wait = 0;
    int eng_dly  = 0;
    int eng_hold = 0;
    int cfg_dly  = 1;
    int cfg_hold = 16;

    initial begin
        active_des_engine_din = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (eng_act) begin
                eng_hold--;
                if (eng_hold <= 0) eng_act = 0;
            end else if (eng_wait) begin
                eng_dly--;
                if (eng_dly <= 0) begin
                    eng_wait = 0;
                    eng_act  = 1;
                    eng_hold = cfg_hold;
                end
            end
            if (start_strobe_dout) begin
                eng_wait = 1;
                eng_dly  = rand_eng ? int'($urandom_range(1, 3)) : cfg_dly;
                if (rand_eng) cfg_hold = int'($urandom_range(1, 20));
            end
            active_des_engine_din = foreign | eng_act;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_job(input logic [0:63] pt, input logic [0:63] k);
        int b;
        b = 0;
        plaintext_din = pt;
        key_din       = k;
        job_valid_din = 1'b1;
        while (!job_ready_dout && b < 300) begin
            step();
            b++;
        end
        if (b >= 300) tmo("push_wait");
        step();
        job_valid_din = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int b;
        b = 0;
        while (strobe_cnt < target && b < budget) begin
            step();
            b++;
        end
        if (strobe_cnt < target) tmo("strobe_wait");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        reset_n       = 1'b0;
        job_valid_din = 1'b0;
        plaintext_din = '0;
        key_din       = '0;

        // Reset then idle
        step(3);
        chk("rst_strobe", 128'(start_strobe_dout),  128'(0));
        chk("rst_pt",     128'(plaintext_dout),     128'(0));
        chk("rst_key",    128'(key_dout),           128'(0));
        chk("rst_count",  128'(pending_count_dout), 128'(0));
        chk("rst_ready",  128'(job_ready_dout),     128'(1));
        reset_n = 1'b1;
        step(20);
        chk("idle_no_strobe", 128'(strobe_cnt), 128'(0));

        // Single job: accepted at E0, strobe E1..E2
        plaintext_din = 64'h0123456789ABCDEF;
        key_din       = 64'h133457799BBCDFF1;
        job_valid_din = 1'b1;
        step();
        job_valid_din = 1'b0;
        chk("e0_count",  128'(pending_count_dout), 128'(1));
        chk("e0_strobe", 128'(start_strobe_dout),  128'(0));
        step();
        chk("e1_strobe", 128'(start_strobe_dout),  128'(1));
        chk("e1_pt",     128'(plaintext_dout),     128'(64'h0123456789ABCDEF));
        chk("e1_key",    128'(key_dout),           128'(64'h133457799BBCDFF1));
        chk("e1_count",  128'(pending_count_dout), 128'(0));
        step();
        chk("e2_strobe", 128'(start_strobe_dout),  128'(0));
        chk("e2_pt",     128'(plaintext_dout),     128'(0));
        step(25);
        chk("single_one_strobe", 128'(strobe_cnt), 128'(1));

        // Back-to-back fill while engine held busy
        foreign = 1;
        step(2);
        base = strobe_cnt;
        for (int i = 0; i < 4; i++) push_job(64'hA000_0000_0000_0000 + 64'(i), 64'hB0 + 64'(i));
        chk("fill_ready", 128'(job_ready_dout),     128'(0));
        chk("fill_count", 128'(pending_count_dout), 128'(4));
        plaintext_din = 64'hA000_0000_0000_0004;
        key_din       = 64'hB4;
        job_valid_din = 1'b1;
        step(3);
        chk("fill_held_ready", 128'(job_ready_dout),     128'(0));
        chk("fill_held_count", 128'(pending_count_dout), 128'(4));
        chk("fill_no_strobe",  128'(strobe_cnt),         128'(base));
        foreign = 0;
        push_job(64'hA000_0000_0000_0004, 64'hB4);
        wait_strobes(base + 5, 600);
        for (int i = 0; i < 5; i++)
            if (base + i < seen_pt.size())
                chk("fill_order", 128'(seen_pt[base + i]), 128'(64'hA000_0000_0000_0000 + 64'(i)));
        step(30);

        // Simultaneous push and pop
        foreign = 1;
        step(2);
        base = strobe_cnt;
        push_job(64'hC0, 64'h1);
        push_job(64'hC1, 64'h2);
        chk("sim_pre_count", 128'(pending_count_dout), 128'(2));
        foreign       = 0;
        plaintext_din = 64'hC2;
        key_din       = 64'h3;
        job_valid_din = 1'b1;
        step();
        job_valid_din = 1'b0;
        chk("sim_count",  128'(pending_count_dout), 128'(2));
        chk("sim_strobe", 128'(start_strobe_dout),  128'(1));
        chk("sim_pt",     128'(plaintext_dout),     128'(64'hC0));
        wait_strobes(base + 3, 600);
        for (int i = 0; i < 3; i++)
            if (base + i < seen_pt.size())
                chk("sim_order", 128'(seen_pt[base + i]), 128'(64'hC0 + 64'(i)));
        step(30);

        // Foreign busy while IDLE
        foreign = 1;
        step(2);
        base = strobe_cnt;
        push_job(64'hD0, 64'hD1);
        step(10);
        chk("foreign_hold", 128'(strobe_cnt), 128'(base));
        foreign = 0;
        step();
        chk("foreign_release", 128'(start_strobe_dout), 128'(1));
        step(30);

        // Reset mid-flight during WAIT_DONE
        cfg_hold = 30;
        base = strobe_cnt;
        push_job(64'hE0, 64'hE1);
        wait_strobes(base + 1, 20);
        push_job(64'hE2, 64'h1);
        push_job(64'hE3, 64'h2);
        push_job(64'hE4, 64'h3);
        step(3);
        chk("mid_count", 128'(pending_count_dout), 128'(3));
        chk("mid_active", 128'(active_des_engine_din), 128'(1));
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        chk("mid_rst_count",  128'(pending_count_dout), 128'(0));
        chk("mid_rst_ready",  128'(job_ready_dout),     128'(1));
        chk("mid_rst_strobe", 128'(start_strobe_dout),  128'(0));
        base = strobe_cnt;
        step(40);
        chk("mid_no_strobe", 128'(strobe_cnt), 128'(base));
        cfg_hold = 16;

        // Randomized phase
        rand_eng = 1;
        for (int c = 0; c < 800; c++) begin
            job_valid_din = ($urandom_range(0, 1) == 1);
            plaintext_din = {$urandom, $urandom};
            key_din       = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) foreign = ~foreign;
            step();
        end
        job_valid_din = 1'b0;
        foreign       = 0;
        step(300);
        chk("drain_count", 128'(pending_count_dout), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
